// File: rtl/tinyqv_uart_pkg.sv
// Shared UART definitions for the tinyqv serial blocks (rx and tx).
// Holds the receiver state encoding, the bit-timer width and helpers that
// turn a clock frequency and bit rate into per-bit and half-bit cycle counts.
package tinyqv_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Wide enough for any sensible clock/baud ratio.
  localparam int CNT_W = 16;

  // Clock cycles per serial bit.
  function automatic int calc_div(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int calc_half(input int clk_hz, input int bit_rate);
    return calc_div(clk_hz, bit_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (pointers only)
//   push, din - write din when not full (or when a pop frees a slot this cycle)
//   pop       - drop the head entry when not empty
//   dout      - head entry, zero when empty
//   count     - occupancy 0..DEPTH
//   full, empty
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 debug UART receiver with a small receive FIFO and sticky error flags.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   uart_rxd      - asynchronous serial input, idle high
//   rx_pop        - pop FIFO head (ignored when empty)
//   err_clr       - clear rx_overrun and rx_frame_err
//   rx_data       - FIFO head byte, 8'h00 when empty
//   rx_valid      - FIFO non-empty
//   rx_count      - FIFO occupancy
//   rx_overrun    - sticky: byte dropped on a full FIFO
//   rx_frame_err  - sticky: stop bit sampled low
module debug_uart_rx
  import tinyqv_uart_pkg::*;
#(
  parameter int CLK_HZ     = 14_000_000,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rx_pop,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [4:0] rx_count,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int DIV  = calc_div(CLK_HZ, BIT_RATE);
  localparam int HALF = calc_half(CLK_HZ, BIT_RATE);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic              sync1_q, rxd_s_q;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              push_req, frame_evt, overrun_evt;
  logic              fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Two-flop synchroniser, idles high so reset looks like an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      rxd_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s_q) begin
          state_d = ST_START;
          cnt_d   = HALF_M1;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxd_s_q) begin
          // Line went back high by mid-start-bit: treat as a glitch.
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = DIV_M1;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rxd_s_q, shift_q[7:1]};
          cnt_d     = DIV_M1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxd_s_q) begin
          push_req = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          // Bad stop bit: drop the byte and wait out a held-low line
          // so a break is not mistaken for a stream of start bits.
          frame_evt = 1'b1;
          state_d   = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A simultaneous pop makes room, so only an unpopped full FIFO overruns.
  assign overrun_evt = push_req && fifo_full && !rx_pop;

  // Set events take priority over err_clr.
  assign overrun_d   = overrun_evt | (overrun_q & ~err_clr);
  assign frame_err_d = frame_evt   | (frame_err_q & ~err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rx_pop),
    .din   (shift_q),
    .dout  (rx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid     = !fifo_empty;
  assign rx_count     = 5'(fifo_count);
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_debug_uart_rx.sv
module tb_debug_uart_rx;

  localparam int DIV   = 14_000_000 / 1_000_000;
  localparam int HALF  = DIV / 2;
  localparam int DEPTH = 4;
  // Posedges from driving the start bit low until the stop-bit sample:
  // 2 synchroniser stages, 1 edge to leave IDLE, HALF to mid-start, 9 bits.
  localparam int STOP_EDGE = 3 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a bounded queue plus two sticky flags.
  logic [7:0] model_q[$];
  logic       model_ovr;
  logic       model_ferr;

  debug_uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .rx_pop       (rx_pop),
    .err_clr      (err_clr),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) model_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; uart_rxd = 1'b1; rx_pop = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_q.delete(); model_ovr = 1'b0; model_ferr = 1'b0;
  endtask

  // Drives one frame, one cycle per iteration starting at a negedge.
  // chg returns the posedge index at which rx_count first changed (-1 if never).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_tail,
                            input int pop_at, input int abort_at, output int chg);
    logic [4:0] c0;
    int pos;
    c0  = rx_count;
    chg = -1;
    for (int i = 0; i < 10 * DIV + low_tail + 4; i++) begin
      if (i > 0) @(negedge clk);
      if (chg < 0 && rx_count != c0) chg = i;
      if (i == abort_at) begin
        rst = 1'b1; uart_rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      pos = i / DIV;
      if (pos == 0)      uart_rxd = 1'b0;
      else if (pos <= 8) uart_rxd = b[pos-1];
      else if (pos == 9) uart_rxd = stop_ok;
      else               uart_rxd = (i >= 10 * DIV + low_tail);
      rx_pop = (i == pop_at);
    end
    rx_pop = 1'b0; uart_rxd = 1'b1;
  endtask

  task automatic pop_once(output logic [7:0] d, output logic v);
    d = rx_data; v = rx_valid;
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      uart_rxd = 1'($urandom);
      @(negedge clk);
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rx_count); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", rx_overrun, rx_frame_err); end
    do_reset();
  endtask

  task automatic test_single();
    int chg;
    logic [7:0] d; logic v;
    do_reset();
    send_frame(8'hA5, 1'b1, 0, -1, -1, chg);
    model_frame(8'hA5, 1'b1);
    n_checks++; if (chg !== STOP_EDGE) begin n_fail++; $display("FAIL single_latency: got edge %0d want %0d", chg, STOP_EDGE); end
    n_checks++; if (rx_valid !== 1'b1 || rx_count !== 5'd1) begin n_fail++; $display("FAIL single_valid: got v=%b c=%0d want v=1 c=1", rx_valid, rx_count); end
    pop_once(d, v);
    n_checks++; if (d !== model_q[0]) begin n_fail++; $display("FAIL single_data: got %h want %h", d, model_q[0]); end
    void'(model_q.pop_front());
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL single_empty: got v=%b d=%h want v=0 d=00", rx_valid, rx_data); end
    pop_once(d, v);
    n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL pop_empty: got %0d want 0", rx_count); end
  endtask

  task automatic test_glitch();
    int chg;
    logic [7:0] b;
    do_reset();
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch: got v=%b o=%b f=%b want 000", rx_valid, rx_overrun, rx_frame_err); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 0, -1, -1, chg);
    n_checks++; if (rx_data !== b || rx_count !== 5'd1) begin n_fail++; $display("FAIL glitch_recover: got %h/%0d want %h/1", rx_data, rx_count, b); end
  endtask

  task automatic test_overrun();
    int chg;
    logic [7:0] d; logic v;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 0, -1, -1, chg);
      model_frame(8'(k), 1'b1);
    end
    n_checks++; if (rx_count !== 5'(model_q.size())) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", rx_count, model_q.size()); end
    n_checks++; if (rx_overrun !== model_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", rx_overrun, model_ovr); end
    while (model_q.size() > 0) begin
      pop_once(d, v);
      n_checks++; if (v !== 1'b1 || d !== model_q[0]) begin n_fail++; $display("FAIL ovr_pop: got v=%b d=%h want v=1 d=%h", v, d, model_q[0]); end
      void'(model_q.pop_front());
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b want 0", rx_valid); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
  endtask

  task automatic test_frame_err();
    int chg;
    logic [7:0] d; logic v;
    do_reset();
    send_frame(8'h3C, 1'b0, 100, -1, -1, chg);
    model_frame(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (rx_frame_err !== model_ferr || rx_count !== 5'd0) begin n_fail++; $display("FAIL ferr_set: got f=%b c=%0d want f=1 c=0", rx_frame_err, rx_count); end
    send_frame(8'h7E, 1'b1, 0, -1, -1, chg);
    model_frame(8'h7E, 1'b1);
    n_checks++; if (rx_count !== 5'(model_q.size())) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", rx_count, model_q.size()); end
    pop_once(d, v);
    n_checks++; if (d !== model_q[0]) begin n_fail++; $display("FAIL ferr_data: got %h want %h", d, model_q[0]); end
    void'(model_q.pop_front());
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr: got %b want 0", rx_frame_err); end
  endtask

  task automatic test_full_pop();
    int chg;
    logic [7:0] b;
    logic [7:0] d; logic v;
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 0, -1, -1, chg);
      model_frame(b, 1'b1);
    end
    b = 8'($urandom);
    // Pop is high across exactly the posedge that samples the stop bit.
    send_frame(b, 1'b1, 0, STOP_EDGE - 1, -1, chg);
    void'(model_q.pop_front());
    model_q.push_back(b);
    n_checks++; if (rx_count !== 5'd4 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop: got c=%0d o=%b want c=4 o=0", rx_count, rx_overrun); end
    while (model_q.size() > 0) begin
      pop_once(d, v);
      n_checks++; if (d !== model_q[0]) begin n_fail++; $display("FAIL fullpop_order: got %h want %h", d, model_q[0]); end
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_rst_mid();
    int chg;
    logic [7:0] d; logic v;
    do_reset();
    send_frame(8'h55, 1'b1, 0, -1, 3 + HALF + 4 * DIV, chg);
    repeat (20) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got v=%b o=%b f=%b want 000", rx_valid, rx_overrun, rx_frame_err); end
    send_frame(8'h81, 1'b1, 0, -1, -1, chg);
    n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", rx_count); end
    pop_once(d, v);
    n_checks++; if (d !== 8'h81 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %h o=%b f=%b want 81 o=0 f=0", d, rx_overrun, rx_frame_err); end
  endtask

  task automatic test_random();
    int chg;
    logic [7:0] b;
    bit ok;
    logic [7:0] d; logic v;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, ok ? 0 : 20, -1, -1, chg);
      model_frame(b, ok);
      n_checks++; if (rx_count !== 5'(model_q.size()) || rx_overrun !== model_ovr || rx_frame_err !== model_ferr) begin n_fail++; $display("FAIL rand_state%0d: got c=%0d o=%b f=%b want c=%0d o=%b f=%b", n, rx_count, rx_overrun, rx_frame_err, model_q.size(), model_ovr, model_ferr); end
      if (model_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        pop_once(d, v);
        n_checks++; if (d !== model_q[0]) begin n_fail++; $display("FAIL rand_pop%0d: got %h want %h", n, d, model_q[0]); end
        void'(model_q.pop_front());
      end
    end
    while (model_q.size() > 0) begin
      pop_once(d, v);
      n_checks++; if (d !== model_q[0]) begin n_fail++; $display("FAIL rand_drain: got %h want %h", d, model_q[0]); end
      void'(model_q.pop_front());
    end
  endtask

  initial begin
    model_ovr = 1'b0; model_ferr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_full_pop();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_uart_rx.md
DEBUG_UART_RX -- requirements
Module: debug_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 14_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 1_000_000, serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port rx_pop  input  1  pops the FIFO head when rx_valid=1.
REQ-008 SHALL have port err_clr  input  1  clears rx_overrun and rx_frame_err.
REQ-009 SHALL have port rx_data  output  8  FIFO head byte; 8'h00 when empty.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_count  output  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 SHALL have port rx_overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-013 SHALL have port rx_frame_err  output  1  sticky flag: a stop bit was sampled low.

Function
REQ-014 SHALL derive DIV = CLK_HZ/BIT_RATE (integer division) and HALF = DIV/2; DIV=14 and HALF=7 at the defaults.
REQ-015 SHALL pass uart_rxd through a 2-flop synchroniser; rxd_s is the second flop output, reset to 1.
REQ-016 SHALL implement an FSM with states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-017 IDLE: when rxd_s=0, SHALL go to START and load the bit counter with HALF-1.
REQ-018 START: the counter SHALL decrement each cycle; at 0, SHALL sample rxd_s.
- rxd_s=1: glitch, return to IDLE; nothing is recorded.
- rxd_s=0: go to DATA, load the counter with DIV-1, and clear the bit index.
REQ-019 DATA: SHALL sample rxd_s each time the counter reaches 0 and reload DIV-1; bits are LSB first; after the 8th sample, SHALL go to STOP.
REQ-020 STOP: SHALL sample at counter 0.
- rxd_s=1: attempt a FIFO push, then go to IDLE.
- rxd_s=0: discard the byte, set rx_frame_err, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: SHALL stay until rxd_s=1, then go to IDLE.
REQ-022 A pushed byte SHALL appear at rx_data/rx_valid on the cycle after the stop-bit sample.
REQ-023 Push while the FIFO is full and rx_pop=0: the byte SHALL be dropped, rx_overrun set, and FIFO contents unchanged.
REQ-024 Push and rx_pop in the same cycle with the FIFO full: both SHALL occur, with no overrun and rx_count unchanged.
REQ-025 rx_pop while empty SHALL be ignored; rx_count never underflows.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit for full/empty discrimination.
REQ-027 err_clr SHALL clear both sticky flags.
- If a set event occurs in the same cycle, the set SHALL win.
REQ-028 The receiver SHALL keep running while the FIFO is full; only the push is suppressed.

Reset
REQ-029 While rst=1, the block SHALL hold the following:
- FSM in IDLE; counter, bit index and shift register at 0.
- Synchroniser flops at 1.
- FIFO pointers at 0; rx_valid=0, rx_count=0, rx_data=8'h00.
- rx_overrun=0, rx_frame_err=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame.
- After release, the block SHALL wait in IDLE for a new falling edge.
- No partial byte SHALL be pushed.
REQ-031 FIFO storage contents need not be reset; only the pointers are.

Structure
REQ-032 Package tinyqv_uart_pkg SHALL hold the FSM state enum and the DIV/HALF computation helper, shared with the uart_tx block.
REQ-033 The FIFO SHALL be a separate sub-module, uart_rx_fifo.
- It SHALL be parameterised by width and depth.
- Its ports SHALL be push, pop, din, dout, count, full and empty.
REQ-034 debug_uart_rx SHALL instantiate exactly one uart_rx_fifo.

Verification (defaults: 14 MHz, 1 Mbaud, DIV=14)
REQ-035 Send 0xA5 with a valid stop bit -> rx_valid=1, rx_data=0xA5 and rx_count=1 on the cycle after the stop-bit sample.
REQ-036 Drive uart_rxd low for 3 cycles, then high -> FSM returns to IDLE; rx_valid stays 0; no flags set.
REQ-037 Send 0x01..0x05 with no pops -> rx_count=4, rx_overrun=1; pops return 0x01..0x04; 0x05 is lost.
REQ-038 Send 0x3C with the stop bit low, line held low 100 cycles, then 0x7E -> rx_frame_err=1; only 0x7E is received.
REQ-039 With the FIFO full, assert rx_pop on the push cycle -> rx_count stays 4 and rx_overrun stays 0.
REQ-040 Assert rst for 1 cycle mid-DATA of 0x55, then send 0x81 -> only 0x81 is received; both flags stay 0.
